// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: PC source encodings, hazard FSM states and the
// hard-wired zero register specifier.
package mips_pipe_pkg;

    localparam logic [1:0] ADDR_PC4    = 2'b00;
    localparam logic [1:0] ADDR_JUMP   = 2'b01;
    localparam logic [1:0] ADDR_BRANCH = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        HZ_IDLE       = 1'b0,
        HZ_BR_RESOLVE = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_stat_counter.sv
// Saturating event counter with synchronous clear; used for hazard statistics.
module hazard_stat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count events, holding at all-ones, cleared synchronously
    always_ff @(posedge clk) begin
        if (clr) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline (load-use, branch, jump).
// Optional statistics counters are enabled by defining HAZARD_STATS_EN.
module hazard_detection_unit
    import mips_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int STAT_W     = 16
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic                  ID_UseRs,
    input  logic                  ID_UseRt,
    input  logic                  ID_Branch,
    input  logic                  ID_Jump,
    input  logic [REG_ADDR_W-1:0] EX_Rw,
    input  logic                  EX_MemRead,
    input  logic                  EX_BranchTaken,
    output logic                  PCWrite,
    output logic                  IFWrite,
    output logic                  IFFlush,
    output logic                  Bubble,
    output logic [1:0]            AddrSel
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0]     StallCount,
    output logic [STAT_W-1:0]     BranchCount,
    output logic [STAT_W-1:0]     JumpCount
`endif
);

    hz_state_t state_r;
    hz_state_t next_state_s;
    logic      load_use_s;

    // Load-use hazard: a load in EX writes a register the ID instruction reads
    assign load_use_s = EX_MemRead
                      && (EX_Rw != REG_ADDR_W'(REG_ZERO))
                      && ((ID_UseRs && (ID_Rs == EX_Rw)) || (ID_UseRt && (ID_Rt == EX_Rw)));

    // Hazard state register
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r <= HZ_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Mealy output and next-state decode
    always_comb begin
        next_state_s = HZ_IDLE;
        PCWrite      = 1'b1;
        IFWrite      = 1'b1;
        IFFlush      = 1'b0;
        Bubble       = 1'b0;
        AddrSel      = ADDR_PC4;
        if (Reset) begin
            PCWrite = 1'b0;
            IFWrite = 1'b0;
            IFFlush = 1'b1;
            Bubble  = 1'b1;
        end else begin
            case (state_r)
                HZ_IDLE: begin
                    if (load_use_s) begin
                        // Stall wins over branch/jump; they are re-seen next cycle
                        PCWrite = 1'b0;
                        IFWrite = 1'b0;
                        Bubble  = 1'b1;
                    end else if (ID_Branch) begin
                        PCWrite      = 1'b0;
                        IFWrite      = 1'b0;
                        next_state_s = HZ_BR_RESOLVE;
                    end else if (ID_Jump) begin
                        AddrSel = ADDR_JUMP;
                        IFFlush = 1'b1;
                    end else begin
                        next_state_s = HZ_IDLE;
                    end
                end
                HZ_BR_RESOLVE: begin
                    // IF/ID holds a duplicate of the branch now in EX
                    Bubble = 1'b1;
                    if (EX_BranchTaken) begin
                        AddrSel = ADDR_BRANCH;
                        IFFlush = 1'b1;
                        IFWrite = 1'b0;
                    end else begin
                        AddrSel = ADDR_PC4;
                        IFWrite = 1'b1;
                    end
                end
                default: begin
                    next_state_s = HZ_IDLE;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic stall_inc_s;
    logic branch_inc_s;
    logic jump_inc_s;

    assign stall_inc_s  = !Reset && (state_r == HZ_IDLE) && load_use_s;
    assign branch_inc_s = !Reset && (state_r == HZ_BR_RESOLVE) && EX_BranchTaken;
    assign jump_inc_s   = !Reset && (state_r == HZ_IDLE) && !load_use_s && !ID_Branch && ID_Jump;

    hazard_stat_counter #(.W(STAT_W)) u_stall_cnt (
        .clk   (CLK),
        .clr   (Reset),
        .inc   (stall_inc_s),
        .count (StallCount)
    );

    hazard_stat_counter #(.W(STAT_W)) u_branch_cnt (
        .clk   (CLK),
        .clr   (Reset),
        .inc   (branch_inc_s),
        .count (BranchCount)
    );

    hazard_stat_counter #(.W(STAT_W)) u_jump_cnt (
        .clk   (CLK),
        .clr   (Reset),
        .inc   (jump_inc_s),
        .count (JumpCount)
    );
`endif

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Stall/flush controller for the 5-stage pipelined MIPS core; complements the forwarding unit.
- Forwarding resolves RAW hazards by bypassing EX/MEM results. This block handles the hazards forwarding cannot resolve: load-use, branch resolution, and jump redirect.
- Sits beside the ID stage. Drives PC write-enable, the IF/ID register enable and flush, the ID/EX bubble mux, and the PC source select.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- STAT_W, 16, width of the optional statistics counters.

Ports:
- CLK  input  1  pipeline clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- ID_Rs  input  REG_ADDR_W  Rs of the instruction in ID.
- ID_Rt  input  REG_ADDR_W  Rt of the instruction in ID.
- ID_UseRs  input  1  ID instruction reads Rs.
- ID_UseRt  input  1  ID instruction reads Rt (0 for immediate-form destinations).
- ID_Branch  input  1  ID instruction is a conditional branch.
- ID_Jump  input  1  ID instruction is j/jal.
- EX_Rw  input  REG_ADDR_W  destination register of the EX instruction.
- EX_MemRead  input  1  EX instruction is a load.
- EX_BranchTaken  input  1  branch condition computed in EX (ALU zero, qualified).
- PCWrite  output  1  PC register enable.
- IFWrite  output  1  IF/ID register enable.
- IFFlush  output  1  load NOP into IF/ID (has priority over IFWrite).
- Bubble  output  1  zero the ID/EX control fields.
- AddrSel  output  2  PC source: 00 = PC+4, 01 = jump target, 10 = branch target, 11 = reserved (never driven).

Behaviour:
- State register: 1 bit. States are IDLE and BR_RESOLVE. Outputs are combinational from state and inputs (Mealy).
- LoadUse = EX_MemRead & (EX_Rw != 0) & ((ID_UseRs & ID_Rs == EX_Rw) | (ID_UseRt & ID_Rt == EX_Rw)). A destination of $0 never hazards.
- Default outputs: PCWrite=1, IFWrite=1, IFFlush=0, Bubble=0, AddrSel=00.
- IDLE, evaluated in priority order:
  1. LoadUse: PCWrite=0, IFWrite=0, Bubble=1; stay IDLE. This gives exactly one stall cycle; the MEM-stage forward covers the next cycle. A load-use stall takes precedence over a simultaneous ID_Branch or ID_Jump; the branch or jump is re-evaluated the next cycle.
  2. ID_Branch: PCWrite=0, IFWrite=0, Bubble=0 (the branch advances to EX); next state BR_RESOLVE.
  3. ID_Jump: AddrSel=01, PCWrite=1, IFFlush=1, Bubble=0; stay IDLE. One-cycle penalty.
  4. Otherwise: defaults.
- ID_Branch and ID_Jump both high is illegal and is treated as a branch.
- BR_RESOLVE: the branch is now in EX and IF/ID still holds the duplicate branch.
  - Always: Bubble=1 (squash the duplicate), PCWrite=1.
  - If EX_BranchTaken: AddrSel=10, IFFlush=1, IFWrite=0.
  - Else: AddrSel=00, IFWrite=1 (latches the fall-through instruction).
  - ID inputs are ignored in this state. Next state is IDLE unconditionally.
  - Branch penalty: 2 cycles taken, 1 cycle not taken.
- Reset=1, whatever the state: outputs are PCWrite=0, IFWrite=0, IFFlush=1, Bubble=1, AddrSel=00. The state becomes IDLE at the clock edge. Reset asserted in BR_RESOLVE abandons the branch; no redirect is issued.
- After reset deasserts, the first cycle is in IDLE with normal evaluation.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, adds three outputs: StallCount, BranchCount, JumpCount, each STAT_W bits.
  - StallCount increments on each LoadUse stall cycle.
  - BranchCount increments on each BR_RESOLVE cycle with EX_BranchTaken=1.
  - JumpCount increments on each IDLE jump redirect.
  - The counters saturate at all-ones and clear on Reset.
- When not defined: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - AddrSel encodings: ADDR_PC4, ADDR_JUMP, ADDR_BRANCH.
  - Hazard state enum: HZ_IDLE, HZ_BR_RESOLVE.
  - REG_ZERO constant.
- One natural sub-module: hazard_stat_counter. It is a saturating STAT_W counter with increment and synchronous clear, instantiated three times under HAZARD_STATS_EN.

Test Plan:
- Load-use: EX_MemRead=1, EX_Rw=5, ID_Rs=5, ID_UseRs=1 → one cycle with PCWrite=0, IFWrite=0, Bubble=1. With EX_MemRead=0 the next cycle, all defaults. Repeat with EX_Rw=0 → no stall.
- Immediate guard: EX_MemRead=1, EX_Rw=5, ID_Rt=5, ID_UseRt=0 → no stall.
- Taken branch: ID_Branch=1 → cycle 0: PCWrite=0, IFWrite=0, Bubble=0. Cycle 1 with EX_BranchTaken=1: AddrSel=10, IFFlush=1, Bubble=1. Cycle 2 returns to defaults. Not-taken variant: cycle 1 gives AddrSel=00, IFWrite=1, IFFlush=0.
- Jump: ID_Jump=1 → AddrSel=01, IFFlush=1, PCWrite=1 for one cycle. ID_Jump together with LoadUse → stall first, then the jump the next cycle.
- Branch behind a load: LoadUse together with ID_Branch → 1 stall cycle, then the branch sequence. Total 3 cycles before the redirect.
- Reset asserted in BR_RESOLVE → reset outputs that cycle, IDLE afterwards, no AddrSel=10 ever issued. With HAZARD_STATS_EN: 3 stalls give StallCount=3, and Reset clears it to 0.
